// File: rtl/snn_evt_pkg.sv
// Shared constants, FSM state encoding and saturation helper for the event-driven LIF core.
package snn_evt_pkg;

  localparam int Q     = 14;
  localparam int W_W   = 16;
  localparam int V_W   = 16;
  localparam int SAT_W = 48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_UPDATE,
    S_OUT
  } state_e;

  localparam logic CFG_WEIGHT = 1'b0;
  localparam logic CFG_VTH    = 1'b1;

  localparam logic signed [V_W-1:0]   V_MAX  = {1'b0, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0]   V_MIN  = {1'b1, {(V_W-1){1'b0}}};
  localparam logic signed [SAT_W-1:0] SAT_HI = SAT_W'(V_MAX);
  localparam logic signed [SAT_W-1:0] SAT_LO = SAT_W'(V_MIN);

  function automatic logic signed [V_W-1:0] sat_v(input logic signed [SAT_W-1:0] x);
    if (x > SAT_HI)      return V_MAX;
    else if (x < SAT_LO) return V_MIN;
    else                 return x[V_W-1:0];
  endfunction

endpackage

// File: rtl/snn_lif_update.sv
// Single-neuron leak/integrate/fire datapath. SNN_SOFT_RESET_EN selects subtractive
// reset on fire; otherwise a firing neuron returns to zero.
module snn_lif_update
  import snn_evt_pkg::*;
#(
  parameter int ACC_W = 23
) (
  input  logic signed [V_W-1:0]   v,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [V_W-1:0]   vth,
  input  logic        [Q:0]       alpha,
  output logic signed [V_W-1:0]   v_next,
  output logic                    spike
);

  logic signed [SAT_W-1:0] v_ext;
  logic signed [SAT_W-1:0] a_ext;
  logic signed [SAT_W-1:0] acc_ext;
  logic signed [SAT_W-1:0] v_leak;
  logic signed [V_W-1:0]   v_sum;
`ifdef SNN_SOFT_RESET_EN
  logic signed [SAT_W-1:0] vth_ext;
`endif

  always_comb begin
    v_ext   = SAT_W'(v);
    a_ext   = SAT_W'(alpha);
    acc_ext = SAT_W'(acc);
    // Both operands are signed, so >>> floors toward -inf rather than truncating.
    v_leak  = (v_ext * a_ext) >>> Q;
    v_sum   = sat_v(v_leak + acc_ext);
    spike   = (v_sum >= vth);
    v_next  = v_sum;
`ifdef SNN_SOFT_RESET_EN
    vth_ext = SAT_W'(vth);
    if (spike) v_next = sat_v(SAT_W'(v_sum) - vth_ext);
`else
    if (spike) v_next = '0;
`endif
  end

endmodule

// File: rtl/snn_core_evt.sv
// Event-driven LIF layer: F binary inputs, N neurons, runtime-writable weights and thresholds.
// Build option SNN_SOFT_RESET_EN (see snn_lif_update) switches to subtractive reset on fire.
module snn_core_evt
  import snn_evt_pkg::*;
#(
  parameter int F         = 48,
  parameter int N         = 96,
  parameter int ALPHA_Q14 = 15474
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic [F-1:0]              event_vec,
  output logic                      sp_valid,
  input  logic                      sp_ready,
  output logic [N-1:0]              spikes_vec,
  input  logic                      cfg_we,
  input  logic                      cfg_sel,
  input  logic [$clog2(F*N)-1:0]    cfg_addr,
  input  logic signed [W_W-1:0]     cfg_data,
  output logic                      cfg_err,
  input  logic                      mem_clr
);

  localparam int A_W   = $clog2(F*N);
  localparam int F_W   = (F > 1) ? $clog2(F) : 1;
  localparam int ACC_W = W_W + $clog2(F) + 1;
  localparam logic [Q:0] ALPHA = (Q+1)'(ALPHA_Q14);

  state_e                  state;
  logic [F-1:0]            pend;
  logic [F_W-1:0]          ffs_idx;
  logic                    addr_ok;
  logic signed [W_W-1:0]   w_mem  [F][N];
  logic signed [V_W-1:0]   vth    [N];
  logic signed [V_W-1:0]   v_mem  [N];
  logic signed [ACC_W-1:0] acc    [N];
  logic signed [V_W-1:0]   v_next [N];
  logic [N-1:0]            spike;

  // NOTE: default first so every path assigns ffs_idx; otherwise a latch is inferred.
  always_comb begin
    ffs_idx = '0;
    for (int f = F-1; f >= 0; f--) begin
      if (pend[f]) ffs_idx = F_W'(f);
    end
  end

  assign addr_ok = (cfg_sel == CFG_WEIGHT) ? (32'(cfg_addr) < 32'(F*N))
                                           : (32'(cfg_addr) < 32'(N));

  // NOTE: config storage is reset as well, because a reset must discard all loaded weights.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < F; f++)
        for (int n = 0; n < N; n++) w_mem[f][n] <= '0;
      for (int n = 0; n < N; n++) vth[n] <= V_MAX;
    end else if (cfg_we && state == S_IDLE) begin
      for (int f = 0; f < F; f++)
        for (int n = 0; n < N; n++)
          if (cfg_sel == CFG_WEIGHT && cfg_addr == A_W'(f*N + n)) w_mem[f][n] <= cfg_data;
      for (int n = 0; n < N; n++)
        if (cfg_sel == CFG_VTH && cfg_addr == A_W'(n)) vth[n] <= V_W'(cfg_data);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pend       <= '0;
      ev_ready   <= 1'b0;
      sp_valid   <= 1'b0;
      spikes_vec <= '0;
      cfg_err    <= 1'b0;
      for (int n = 0; n < N; n++) begin
        acc[n]   <= '0;
        v_mem[n] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && !(state == S_IDLE && addr_ok);
      unique case (state)
        S_IDLE: begin
          ev_ready <= 1'b1;
          if (mem_clr)
            for (int n = 0; n < N; n++) v_mem[n] <= '0;
          if (ev_valid && ev_ready) begin
            pend     <= event_vec;
            ev_ready <= 1'b0;
            state    <= S_ACCUM;
            for (int n = 0; n < N; n++) acc[n] <= '0;
          end
        end
        S_ACCUM: begin
          if (pend == '0) begin
            state <= S_UPDATE;
          end else begin
            for (int n = 0; n < N; n++) acc[n] <= acc[n] + ACC_W'(w_mem[ffs_idx][n]);
            pend[ffs_idx] <= 1'b0;
          end
        end
        S_UPDATE: begin
          for (int n = 0; n < N; n++) v_mem[n] <= v_next[n];
          spikes_vec <= spike;
          sp_valid   <= 1'b1;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (sp_ready) begin
            sp_valid <= 1'b0;
            ev_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_lif
    snn_lif_update #(.ACC_W(ACC_W)) u_lif (
      .v      (v_mem[n]),
      .acc    (acc[n]),
      .vth    (vth[n]),
      .alpha  (ALPHA),
      .v_next (v_next[n]),
      .spike  (spike[n])
    );
  end

endmodule

// File: tb/tb_snn_core_evt.sv
// Scoreboard bench for snn_core_evt (F=4, N=3, leak factor 0.5); honours SNN_SOFT_RESET_EN.
module tb_snn_core_evt;
  import snn_evt_pkg::*;

  localparam int F = 4;
  localparam int N = 3;
  localparam int ALPHA_Q14 = 8192;
  localparam int A_W = $clog2(F*N);
`ifdef SNN_SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic ev_valid = 1'b0, ev_ready, sp_valid, sp_ready = 1'b1;
  logic cfg_we = 1'b0, cfg_sel = 1'b0, cfg_err, mem_clr = 1'b0;
  logic [F-1:0] event_vec = '0;
  logic [N-1:0] spikes_vec;
  logic [A_W-1:0] cfg_addr = '0;
  logic signed [W_W-1:0] cfg_data = '0;

  typedef struct {
    logic [N-1:0] spikes;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int n_checks = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
  logic in_out = 1'b0;
  logic [N-1:0] held;

  snn_core_evt #(.F(F), .N(N), .ALPHA_Q14(ALPHA_Q14)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready), .event_vec(event_vec),
    .sp_valid(sp_valid), .sp_ready(sp_ready), .spikes_vec(spikes_vec),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .mem_clr(mem_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: timestamps accepts, pops the scoreboard on each new output, checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      in_out = 1'b0;
    end else begin
      if (ev_valid && ev_ready) acc_cyc = cyc + 1;
      if (sp_valid && !in_out) begin
        in_out = 1'b1;
        held   = spikes_vec;
        if (sb.size() == 0) begin
          check("unexpected_sp_valid", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("spikes", spikes_vec, cur.spikes);
          check("latency", cyc - acc_cyc, cur.lat);
        end
      end else if (sp_valid) begin
        check("spikes_stable", spikes_vec, held);
      end
      if (sp_valid && sp_ready) in_out = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!ev_ready && k < 200) begin
      tick();
      k++;
    end
    if (!ev_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic cfg_write(input logic sel, input int addr, input int data, input bit exp_err);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = A_W'(addr); cfg_data = W_W'(data);
    tick();
    cfg_we = 1'b0;
    check("cfg_err", cfg_err, exp_err);
  endtask

  task automatic pulse_clr();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  task automatic push_exp(input logic [N-1:0] sp, input int lat);
    exp_t e;
    e.spikes = sp;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  task automatic send_step(input logic [F-1:0] vec, input logic [N-1:0] sp, input int lat);
    wait_idle();
    push_exp(sp, lat);
    event_vec = vec; ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0; cfg_we = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ev_ready", ev_ready, 0);
    check("rst_sp_valid", sp_valid, 0);
    check("rst_spikes", spikes_vec, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    tick();
    check("ev_ready_after_rst", ev_ready, 1);

    // Basic fire; w[2][0] is written in the same cycle as the accept and must be used
    cfg_write(CFG_WEIGHT, 0, 100, 1'b0);
    cfg_write(CFG_VTH, 0, 120, 1'b0);
    cfg_we = 1'b1; cfg_sel = CFG_WEIGHT; cfg_addr = A_W'(6); cfg_data = 16'sd50;
    send_step(4'b0101, 3'b001, 4);
    check("t1_v0", dut.v_mem[0], SOFT ? 30 : 0);

    // Leak sequence on neuron 1
    cfg_write(CFG_WEIGHT, 0, 0, 1'b0);
    cfg_write(CFG_WEIGHT, 1, 64, 1'b0);
    cfg_write(CFG_VTH, 1, 1000, 1'b0);
    pulse_clr();
    check("mem_clr_v0", dut.v_mem[0], 0);
    send_step(4'b0001, 3'b000, 3);
    check("leak_v1_a", dut.v_mem[1], 64);
    send_step(4'b0001, 3'b000, 3);
    check("leak_v1_b", dut.v_mem[1], 96);
    send_step(4'b0001, 3'b000, 3);
    check("leak_v1_c", dut.v_mem[1], 112);

    // All-zero input: leak only
    send_step(4'b0000, 3'b000, 2);
    check("zero_v1", dut.v_mem[1], 56);
    check("zero_v0", dut.v_mem[0], 0);

    // Backpressure: second request held on ev_valid must wait for the handshake
    cfg_write(CFG_VTH, 1, 50, 1'b0);
    sp_ready = 1'b0;
    wait_idle();
    push_exp(3'b010, 3);
    event_vec = 4'b0001; ev_valid = 1'b1;
    tick();
    push_exp(3'b000, 2);
    event_vec = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("bp_ev_ready", ev_ready, 0);
    end
    check("bp_sp_valid", sp_valid, 1);
    sp_ready = 1'b1;
    wait_idle();
    tick();
    ev_valid = 1'b0;
    wait_idle();
    check("bp_v1", dut.v_mem[1], SOFT ? 21 : 0);

    // Config guard: write during ACCUM is dropped
    wait_idle();
    push_exp(3'b010, 6);
    event_vec = 4'b1111; ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    cfg_write(CFG_WEIGHT, 2, 999, 1'b1);
    tick();
    check("cfg_err_pulse_end", cfg_err, 0);
    wait_idle();
    check("guard_v0", dut.v_mem[0], 50);
    check("guard_v1", dut.v_mem[1], SOFT ? 24 : 0);
    send_step(4'b0001, 3'b010, 3);
    check("guard_w_unchanged_v2", dut.v_mem[2], 0);
    check("guard_v1_b", dut.v_mem[1], SOFT ? 26 : 0);
    cfg_write(CFG_WEIGHT, F*N, 7, 1'b1);
    cfg_write(CFG_VTH, N, 7, 1'b1);

    // Saturation both directions
    pulse_clr();
    for (int f = 0; f < F; f++) begin
      cfg_write(CFG_WEIGHT, f*N + 0, 32767, 1'b0);
      cfg_write(CFG_WEIGHT, f*N + 2, -32768, 1'b0);
    end
    cfg_write(CFG_VTH, 0, 32767, 1'b0);
    send_step(4'b1111, 3'b011, 6);
    check("sat_v0", dut.v_mem[0], 0);
    check("sat_v2", dut.v_mem[2], -32768);
    check("sat_v1", dut.v_mem[1], SOFT ? 14 : 0);

    // Leak of a negative odd value floors toward -inf
    pulse_clr();
    cfg_write(CFG_WEIGHT, 2, -3, 1'b0);
    send_step(4'b0001, 3'b011, 3);
    check("floor_v2_a", dut.v_mem[2], -3);
    send_step(4'b0000, 3'b000, 2);
    check("floor_v2_b", dut.v_mem[2], -2);
    check("floor_v1", dut.v_mem[1], SOFT ? 7 : 0);

    // Reset mid-ACCUM aborts the step and clears config
    wait_idle();
    event_vec = 4'b1111; ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_sp_valid", sp_valid, 0);
    check("mid_rst_spikes", spikes_vec, 0);
    check("mid_rst_ev_ready", ev_ready, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    check("mid_rst_v2", dut.v_mem[2], 0);
    rst = 1'b0;
    tick();
    check("mid_rst_ev_ready_after", ev_ready, 1);
    send_step(4'b1111, 3'b000, 6);
    check("post_rst_v2", dut.v_mem[2], 0);
    check("post_rst_v0", dut.v_mem[0], 0);

    tick(); tick();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_core_evt.md
Name: snn_core_evt

Overview:
- Event-driven successor to snn_core: a parametrised leaky-integrate-and-fire layer of N neurons driven by F binary input channels.
- Weights and thresholds are runtime-writable through a config port instead of being preloaded ROMs.
- Time steps are exchanged with valid/ready handshakes on input events and output spikes.
- Per step, only set input bits are scanned: one weight row per cycle is added to all N current accumulators in parallel, then one leak/integrate/fire cycle runs.

Parameters:
- F, 48, input channels.
- N, 96, neurons.
- Q, 14, fractional bits of leak factor.
- ALPHA_Q14, 15474, leak factor in Q.Q format, range 0..2^Q.
- W_W, 16, signed weight width.
- V_W, 16, signed membrane/threshold width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ev_valid  in  1  event vector valid.
- ev_ready  out  1  core can accept a step (high only in IDLE).
- event_vec  in  F  input spikes for one time step.
- sp_valid  out  1  spikes_vec holds a completed step.
- sp_ready  in  1  downstream accepts spikes.
- spikes_vec  out  N  output spikes of the step.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = weight, 1 = threshold.
- cfg_addr  in  $clog2(F*N)  weight index f*N+n, or neuron n for threshold.
- cfg_data  in  W_W  signed write data.
- cfg_err  out  1  one-cycle pulse: write dropped (not IDLE, or address out of range).
- mem_clr  in  1  zero all membranes (honoured in IDLE only).

Behaviour:
- Reset values:
  - weights 0, thresholds 16'sh7FFF, membranes 0.
  - spikes_vec 0, sp_valid 0, ev_ready 0 on the reset cycle and 1 from the following cycle, cfg_err 0.
  - State is IDLE.
- FSM states IDLE -> ACCUM -> UPDATE -> OUT -> IDLE.
- IDLE:
  - ev_ready=1.
  - On ev_valid: latch event_vec into a pending mask, clear the N accumulators, go to ACCUM.
  - cfg writes and mem_clr are accepted only here. If cfg_we and ev_valid arrive together, the config write commits first and the step uses the new value.
- ACCUM:
  - Each cycle, select the lowest set bit f of the pending mask (find-first-set), add weights[f][n] to acc[n] for all n, clear bit f.
  - When the mask is empty (including an all-zero input), go to UPDATE.
  - acc width is W_W+$clog2(F)+1, so accumulation cannot overflow.
- UPDATE, one cycle:
  - v_leak = (v * ALPHA_Q14) >>> Q, an arithmetic shift (floor toward -inf).
  - v_sum = v_leak + acc, saturated to the signed V_W range.
  - If v_sum >= vth[n]: spike[n]=1 and v <= 0; otherwise spike[n]=0 and v <= v_sum.
  - Register spikes_vec, assert sp_valid, go to OUT.
- OUT:
  - Hold spikes_vec and sp_valid stable until sp_ready.
  - On the handshake cycle, drop sp_valid and return to IDLE. spikes_vec keeps its last value.
- Latency: accept -> sp_valid = popcount(event_vec)+2 cycles. Step throughput = popcount+3 cycles when sp_ready=1.
- rst mid-step: abort immediately and return all state to reset values. Config contents are lost.
- Saturation: results clamp to +32767 / -32768 for V_W=16.

Optional Feature:
- Macro SNN_SOFT_RESET_EN.
- Defined: a firing neuron sets v <= sat(v_sum - vth[n]) (subtractive reset).
- Undefined: a firing neuron sets v <= 0.
- Spike decision and all other timing are identical in both builds.

Decomposition:
- Package snn_evt_pkg:
  - Q, W_W, V_W.
  - FSM state enum.
  - cfg_sel encodings (CFG_WEIGHT=0, CFG_VTH=1).
  - Function sat_v() clamping to V_W.
- Sub-module snn_lif_update: single-neuron leak/integrate/fire/reset datapath (v, acc, vth, ALPHA_Q14 in; v_next, spike out), instantiated N times via generate.
- The top level holds the FSM, the find-first-set logic and the weight/threshold registers.

Test Plan:
- Config: F=4, N=2, ALPHA_Q14=16384.
  - Write w[0][0]=100, w[2][0]=50, vth[0]=120.
  - Send event_vec=4'b0101, sp_ready=1.
  - Expect sp_valid 4 cycles after accept, spikes_vec[0]=1, v0=0 (with SNN_SOFT_RESET_EN: v0=30).
- Leak:
  - ALPHA_Q14=8192, w[0][1]=64, vth[1]=1000.
  - Three steps of event_vec=0001.
  - Expect v1 = 64, 96, 112 and no spikes.
- All-zero event_vec:
  - Expect sp_valid 2 cycles after accept, spikes_vec=0, membranes leak only.
- Backpressure:
  - sp_ready=0 for 10 cycles.
  - Expect spikes_vec stable, ev_ready=0 throughout, and no second accept until handshake.
- Config guard:
  - cfg_we during ACCUM -> cfg_err pulse, weight unchanged.
  - cfg_addr=F*N in IDLE -> cfg_err pulse.
- Saturation and reset:
  - w=32767 on 4 channels, vth=32767 -> v clamps to 32767 and fires.
  - Assert rst mid-ACCUM -> next cycle sp_valid=0, all outputs at reset values, and ev_ready=1 the cycle after rst deasserts.
